// File: rtl/riscv_lsu_if.sv
// Data-memory bus between the load/store unit and the data memory port.
// The LSU drives request, write, address, byte enables and store data.
// The memory answers with grant, read-valid and read data.
interface riscv_lsu_if #(
    parameter int WORD_LENGTH = 32
);
    logic                   mem_req;
    logic                   mem_we;
    logic [WORD_LENGTH-1:0] mem_addr;
    logic [3:0]             mem_be;
    logic [WORD_LENGTH-1:0] mem_wdata;
    logic                   mem_gnt;
    logic                   mem_rvalid;
    logic [WORD_LENGTH-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store unit between execute and the data-memory bus.
// One access is outstanding at a time. Loads return lane-selected, sign- or
// zero-extended data to the writeback mux.
// Optional feature macro: RISCV_LSU_MISALIGN_TRAP_EN. When it is defined,
// misaligned accesses finish without a bus request and flag lsu_misalign.
// When it is not defined, the offending low address bits are ignored and the
// access runs normally on the bus.
//
// state  | meaning
// IDLE   | waiting for lsu_valid; operands latched on accept
// REQ    | mem_req high, memory outputs held until mem_gnt
// RESP   | load granted, waiting for mem_rvalid
// DONE   | one-cycle lsu_done pulse; lsu_valid ignored
module riscv_lsu #(
    parameter int WORD_LENGTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   lsu_valid,
    input  logic                   lsu_we,
    input  logic [2:0]             lsu_funct3,
    input  logic [WORD_LENGTH-1:0] lsu_addr,
    input  logic [WORD_LENGTH-1:0] lsu_wdata,
    output logic                   lsu_busy,
    output logic                   lsu_done,
    output logic [WORD_LENGTH-1:0] lsu_rdata,
    output logic                   lsu_misalign,
    riscv_lsu_if.master            mem
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Access size: 0 = byte, 1 = halfword, 2 = word (reserved codes act as word).
    function automatic logic [1:0] f_size(input logic [2:0] funct3);
        logic [1:0] v_size;
        case (funct3)
            3'b000, 3'b100: v_size = 2'd0;
            3'b001, 3'b101: v_size = 2'd1;
            default:        v_size = 2'd2;
        endcase
        return v_size;
    endfunction

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_we;
    logic [2:0]             r_funct3;
    logic [WORD_LENGTH-1:0] r_addr;
    logic [WORD_LENGTH-1:0] r_wdata;
    logic [WORD_LENGTH-1:0] r_rdata;

    logic                   w_accept;
    logic                   w_trap;
    logic                   w_in_req;
    logic [1:0]             w_size;
    logic                   w_unsigned;
    logic [3:0]             w_be;
    logic [WORD_LENGTH-1:0] w_wdata;
    logic [4:0]             w_lane_shift;
    logic [WORD_LENGTH-1:0] w_shifted;
    logic [WORD_LENGTH-1:0] w_ext;

    assign w_accept = (r_state == S_IDLE) && lsu_valid;

`ifdef RISCV_LSU_MISALIGN_TRAP_EN
    logic [1:0] w_in_size;
    logic       w_in_misalign;
    logic       r_misalign;

    assign w_in_size     = f_size(lsu_funct3);
    assign w_in_misalign = ((w_in_size == 2'd1) && lsu_addr[0]) ||
                           ((w_in_size == 2'd2) && (lsu_addr[1:0] != 2'b00));
    assign w_trap        = w_in_misalign;

    // Remember whether the accepted access was trapped, for the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misalign <= 1'b0;
        end else if (w_accept) begin
            r_misalign <= w_in_misalign;
        end
    end

    assign lsu_misalign = lsu_done & r_misalign;
`else
    assign w_trap       = 1'b0;
    assign lsu_misalign = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; stale rvalid outside RESP is ignored here by construction.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (lsu_valid) begin
                    w_state_nxt = w_trap ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (mem.mem_gnt) begin
                    w_state_nxt = r_we ? S_DONE : S_RESP;
                end
            end
            S_RESP: begin
                if (mem.mem_rvalid) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Latch the operands when an access is accepted; they stay fixed until DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we     <= 1'b0;
            r_funct3 <= 3'b000;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else if (w_accept) begin
            r_we     <= lsu_we;
            r_funct3 <= lsu_funct3;
            r_addr   <= lsu_addr;
            r_wdata  <= lsu_wdata;
        end
    end

    assign w_size     = f_size(r_funct3);
    assign w_unsigned = (r_funct3 == 3'b100) || (r_funct3 == 3'b101);

    // Store lane placement. Halfwords only look at addr[1], so a misaligned
    // halfword lands in the aligned lane when trapping is off.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = r_wdata;
        case (w_size)
            2'd0: begin
                w_wdata = {4{r_wdata[7:0]}};
                if (r_we) begin
                    w_be = 4'b0001 << r_addr[1:0];
                end
            end
            2'd1: begin
                w_wdata = {2{r_wdata[15:0]}};
                if (r_we) begin
                    w_be = 4'b0011 << {r_addr[1], 1'b0};
                end
            end
            default: begin
                w_wdata = r_wdata;
            end
        endcase
    end

    // Load lane select and extension.
    always_comb begin
        w_lane_shift = 5'd0;
        case (w_size)
            2'd0:    w_lane_shift = {r_addr[1:0], 3'b000};
            2'd1:    w_lane_shift = {r_addr[1], 4'b0000};
            default: w_lane_shift = 5'd0;
        endcase
    end

    assign w_shifted = mem.mem_rdata >> w_lane_shift;

    always_comb begin
        w_ext = mem.mem_rdata;
        case (w_size)
            2'd0:    w_ext = {{24{~w_unsigned & w_shifted[7]}}, w_shifted[7:0]};
            2'd1:    w_ext = {{16{~w_unsigned & w_shifted[15]}}, w_shifted[15:0]};
            default: w_ext = mem.mem_rdata;
        endcase
    end

    // Load result register; only a completing load updates it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if ((r_state == S_RESP) && mem.mem_rvalid) begin
            r_rdata <= w_ext;
        end
    end

    // Memory outputs are driven only while requesting, so they read 0 otherwise.
    assign w_in_req      = (r_state == S_REQ);
    assign mem.mem_req   = w_in_req;
    assign mem.mem_we    = w_in_req & r_we;
    assign mem.mem_addr  = w_in_req ? {r_addr[WORD_LENGTH-1:2], 2'b00} : '0;
    assign mem.mem_be    = w_in_req ? w_be : 4'b0000;
    assign mem.mem_wdata = w_in_req ? w_wdata : '0;

    assign lsu_done  = (r_state == S_DONE);
    assign lsu_busy  = lsu_valid & ~lsu_done;
    assign lsu_rdata = r_rdata;

endmodule

// File: tb/tb_riscv_lsu.sv
// Testbench for riscv_lsu: scripted memory responder, behavioural model of the
// access rules, and a per-cycle compare process.
module tb_riscv_lsu;

`ifdef RISCV_LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        lsu_valid = 1'b0;
    logic        lsu_we = 1'b0;
    logic [2:0]  lsu_funct3 = 3'b000;
    logic [31:0] lsu_addr = '0;
    logic [31:0] lsu_wdata = '0;
    logic        lsu_busy;
    logic        lsu_done;
    logic [31:0] lsu_rdata;
    logic        lsu_misalign;

    riscv_lsu_if mem_if ();

    riscv_lsu dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lsu_valid    (lsu_valid),
        .lsu_we       (lsu_we),
        .lsu_funct3   (lsu_funct3),
        .lsu_addr     (lsu_addr),
        .lsu_wdata    (lsu_wdata),
        .lsu_busy     (lsu_busy),
        .lsu_done     (lsu_done),
        .lsu_rdata    (lsu_rdata),
        .lsu_misalign (lsu_misalign),
        .mem          (mem_if)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    // Expected per-cycle outputs, written by the driver, read by the compare process.
    bit          chk_en = 1'b0;
    logic        exp_req = 1'b0;
    logic        exp_done = 1'b0;
    logic        exp_mis = 1'b0;
    logic        exp_store = 1'b0;
    logic        exp_zero = 1'b1;
    logic [31:0] exp_addr = '0;
    logic [3:0]  exp_be = '0;
    logic [31:0] exp_wdata = '0;
    logic [31:0] exp_rdata = '0;

    // Observations used by directed checks.
    int          acc_cyc = 0;
    int          last_done_cyc = -1;
    logic        last_done_mis = 1'b0;
    int          req_cnt = 0;
    logic        prev_req = 1'b0;
    logic [31:0] cap_addr = '0;
    logic [3:0]  cap_be = '0;
    logic [31:0] cap_wdata = '0;
    logic        cap_we = 1'b0;

    bit [31:0] memw [int];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int m_size(input bit [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic bit m_unsigned(input bit [2:0] f3);
        return (f3 == 3'd4) || (f3 == 3'd5);
    endfunction

    function automatic bit m_misaligned(input bit [2:0] f3, input bit [31:0] addr);
        return (addr % m_size(f3)) != 0;
    endfunction

    function automatic bit [3:0] m_be(input bit we, input bit [2:0] f3, input bit [31:0] addr);
        int sz;
        sz = m_size(f3);
        if (!we || sz == 4) return 4'hF;
        if (sz == 1) return 4'(1 << (addr % 4));
        return 4'(3 << ((addr % 4) & 2));
    endfunction

    function automatic bit [31:0] m_wdata(input bit [2:0] f3, input bit [31:0] wd);
        int sz;
        sz = m_size(f3);
        if (sz == 1) return (wd & 32'hFF) * 32'h01010101;
        if (sz == 2) return (wd & 32'hFFFF) * 32'h00010001;
        return wd;
    endfunction

    function automatic bit [31:0] m_load(input bit [2:0] f3, input bit [31:0] addr, input bit [31:0] word);
        int sz;
        int off;
        bit [31:0] v;
        bit [31:0] mask;
        sz = m_size(f3);
        if (sz == 4) return word;
        off = (sz == 1) ? int'(addr % 4) : (int'(addr % 4) & 2);
        v = word >> (8 * off);
        mask = (32'd1 << (8 * sz)) - 32'd1;
        v = v & mask;
        if (!m_unsigned(f3) && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic bit [31:0] get_word(input int k);
        if (!memw.exists(k)) memw[k] = $urandom;
        return memw[k];
    endfunction

    // ---------------- compare process ----------------
    always @(posedge clk) cyc = cyc + 1;

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            cmp("mem_req", {31'd0, mem_if.mem_req}, {31'd0, exp_req});
            cmp("lsu_done", {31'd0, lsu_done}, {31'd0, exp_done});
            cmp("lsu_misalign", {31'd0, lsu_misalign}, {31'd0, exp_mis});
            cmp("lsu_busy", {31'd0, lsu_busy}, {31'd0, lsu_valid & ~exp_done});
            cmp("lsu_rdata", lsu_rdata, exp_rdata);
            if (exp_req) begin
                cmp("mem_addr", mem_if.mem_addr, exp_addr);
                cmp("mem_be", {28'd0, mem_if.mem_be}, {28'd0, exp_be});
                cmp("mem_we", {31'd0, mem_if.mem_we}, {31'd0, exp_store});
                if (exp_store) cmp("mem_wdata", mem_if.mem_wdata, exp_wdata);
            end
            if (exp_zero) begin
                cmp("zero_addr", mem_if.mem_addr, 32'd0);
                cmp("zero_be", {28'd0, mem_if.mem_be}, 32'd0);
                cmp("zero_we", {31'd0, mem_if.mem_we}, 32'd0);
                cmp("zero_wdata", mem_if.mem_wdata, 32'd0);
            end
            if (lsu_done) begin
                last_done_cyc = cyc;
                last_done_mis = lsu_misalign;
            end
            if (mem_if.mem_req) begin
                req_cnt++;
                if (!prev_req) begin
                    cap_addr  = mem_if.mem_addr;
                    cap_be    = mem_if.mem_be;
                    cap_wdata = mem_if.mem_wdata;
                    cap_we    = mem_if.mem_we;
                end
            end
            prev_req = mem_if.mem_req;
        end
    end

    // ---------------- stimulus ----------------
    task automatic noise();
        mem_if.mem_rvalid = ($urandom % 4 == 0);
        mem_if.mem_rdata  = $urandom;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            lsu_valid = 1'b0;
            mem_if.mem_gnt = 1'b0;
            mem_if.mem_rvalid = 1'b0;
        end
    endtask

    // One access, scripted cycle by cycle: gd cycles without grant, then rd
    // cycles without rvalid. With rst_resp set, reset hits the first RESP cycle.
    task automatic run_txn(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                           input bit [31:0] wd, input int gd, input int rd, input bit rst_resp);
        int g;
        int r;
        int k;
        int phase;
        bit trapped;
        bit [31:0] word;
        bit [3:0] be;
        bit [31:0] wrep;
        trapped = TRAP && m_misaligned(f3, addr);
        k = int'(addr >> 2);
        be = m_be(we, f3, addr);
        wrep = m_wdata(f3, wd);
        @(negedge clk);
        lsu_valid = 1'b1;
        lsu_we = we;
        lsu_funct3 = f3;
        lsu_addr = addr;
        lsu_wdata = wd;
        mem_if.mem_gnt = 1'b0;
        noise();
        acc_cyc = cyc;
        req_cnt = 0;
        exp_zero = 1'b0;
        if (trapped) begin
            exp_done = 1'b1;
            exp_mis = 1'b1;
            phase = 3;
        end else begin
            exp_req = 1'b1;
            exp_addr = addr & ~32'd3;
            exp_be = be;
            exp_wdata = wrep;
            exp_store = we;
            phase = 1;
        end
        g = gd;
        r = rd;
        while (phase != 0) begin
            @(negedge clk);
            case (phase)
                1: begin
                    noise();
                    if (g > 0) begin
                        g--;
                        mem_if.mem_gnt = 1'b0;
                    end else begin
                        mem_if.mem_gnt = 1'b1;
                        exp_req = 1'b0;
                        if (we) begin
                            word = get_word(k);
                            for (int i = 0; i < 4; i++)
                                if (be[i]) word[8*i +: 8] = wrep[8*i +: 8];
                            memw[k] = word;
                            exp_done = 1'b1;
                            phase = 3;
                        end else begin
                            phase = 2;
                        end
                    end
                end
                2: begin
                    mem_if.mem_gnt = 1'b0;
                    if (rst_resp) begin
                        rst_n = 1'b0;
                        lsu_valid = 1'b0;
                        mem_if.mem_rvalid = 1'b0;
                        exp_req = 1'b0;
                        exp_done = 1'b0;
                        exp_mis = 1'b0;
                        exp_rdata = '0;
                        exp_zero = 1'b1;
                        #1;
                        cmp("async_rst_req", {31'd0, mem_if.mem_req}, 32'd0);
                        cmp("async_rst_rdata", lsu_rdata, 32'd0);
                        cmp("async_rst_addr", mem_if.mem_addr, 32'd0);
                        phase = 0;
                    end else if (r > 0) begin
                        r--;
                        mem_if.mem_rvalid = 1'b0;
                    end else begin
                        word = get_word(k);
                        mem_if.mem_rvalid = 1'b1;
                        mem_if.mem_rdata = word;
                        exp_rdata = m_load(f3, addr, word);
                        exp_done = 1'b1;
                        phase = 3;
                    end
                end
                default: begin
                    mem_if.mem_gnt = 1'b0;
                    noise();
                    lsu_valid = ($urandom % 2 == 1);
                    exp_done = 1'b0;
                    exp_mis = 1'b0;
                    phase = 0;
                end
            endcase
        end
    endtask

    initial begin
        int saved;
        int sdone;
        mem_if.mem_gnt = 1'b0;
        mem_if.mem_rvalid = 1'b0;
        mem_if.mem_rdata = '0;
        #2;
        rst_n = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cmp("reset_rdata", lsu_rdata, 32'd0);
        cmp("reset_done", {31'd0, lsu_done}, 32'd0);

        // Pin the model with hand-computed values.
        cmp("model_lb", m_load(3'd0, 32'h2002, 32'h12F45678), 32'hFFFFFFF4);
        cmp("model_lhu", m_load(3'd5, 32'h2002, 32'h80010000), 32'h00008001);
        cmp("model_sb_be", {28'd0, m_be(1'b1, 3'd0, 32'h1003)}, 32'h8);
        cmp("model_sh_be", {28'd0, m_be(1'b1, 3'd1, 32'h1002)}, 32'hC);
        cmp("model_sb_wdata", m_wdata(3'd0, 32'h000000AB), 32'hABABABAB);

        // SB, zero-wait.
        run_txn(1'b1, 3'd0, 32'h1003, 32'h000000AB, 0, 0, 1'b0);
        cmp("sb_addr", cap_addr, 32'h1000);
        cmp("sb_be", {28'd0, cap_be}, 32'h8);
        cmp("sb_wdata", cap_wdata, 32'hABABABAB);
        cmp("sb_we", {31'd0, cap_we}, 32'd1);
        cmp("sb_latency", last_done_cyc - acc_cyc, 2);

        // LB / LBU.
        memw[32'h2002 >> 2] = 32'h12F45678;
        run_txn(1'b0, 3'd0, 32'h2002, 32'd0, 0, 0, 1'b0);
        cmp("lb_rdata", lsu_rdata, 32'hFFFFFFF4);
        cmp("lb_latency", last_done_cyc - acc_cyc, 3);
        run_txn(1'b0, 3'd4, 32'h2002, 32'd0, 0, 0, 1'b0);
        cmp("lbu_rdata", lsu_rdata, 32'h000000F4);

        // LH with grant and rvalid stalls.
        memw[32'h2002 >> 2] = 32'h80010000;
        run_txn(1'b0, 3'd1, 32'h2002, 32'd0, 3, 2, 1'b0);
        cmp("lh_req_cycles", req_cnt, 4);
        cmp("lh_rdata", lsu_rdata, 32'hFFFF8001);
        cmp("lh_latency", last_done_cyc - acc_cyc, 8);

        // LW at 0x3001.
        memw[32'h3000 >> 2] = 32'h11223344;
        run_txn(1'b0, 3'd2, 32'h3001, 32'd0, 0, 0, 1'b0);
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
        cmp("lw_mis_latency", last_done_cyc - acc_cyc, 1);
        cmp("lw_mis_flag", {31'd0, last_done_mis}, 32'd1);
        cmp("lw_mis_noreq", req_cnt, 0);
        cmp("lw_mis_rdata_kept", lsu_rdata, 32'hFFFF8001);
`else
        cmp("lw_mis_addr", cap_addr, 32'h3000);
        cmp("lw_mis_latency", last_done_cyc - acc_cyc, 3);
        cmp("lw_mis_rdata", lsu_rdata, 32'h11223344);
`endif

        // Reset during RESP, then a stale rvalid.
        idle(1);
        saved = last_done_cyc;
        run_txn(1'b0, 3'd2, 32'h500, 32'd0, 0, 3, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_if.mem_rvalid = 1'b1;
        mem_if.mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        mem_if.mem_rvalid = 1'b0;
        idle(2);
        cmp("rst_no_done", last_done_cyc, saved);
        memw[32'h504 >> 2] = 32'h0BADF00D;
        run_txn(1'b0, 3'd2, 32'h504, 32'd0, 0, 0, 1'b0);
        cmp("after_rst_rdata", lsu_rdata, 32'h0BADF00D);

        // SW then LW back-to-back.
        run_txn(1'b1, 3'd2, 32'h40, 32'hDEADBEEF, 0, 0, 1'b0);
        cmp("sw_be", {28'd0, cap_be}, 32'hF);
        sdone = last_done_cyc;
        run_txn(1'b0, 3'd2, 32'h40, 32'd0, 0, 0, 1'b0);
        cmp("b2b_accept", acc_cyc, sdone + 1);
        cmp("b2b_rdata", lsu_rdata, 32'hDEADBEEF);

        // Randomized traffic over a small window so stores and loads overlap.
        for (int n = 0; n < 250; n++) begin
            run_txn(1'($urandom % 2), 3'($urandom % 8),
                    32'h100 + ($urandom % 16) * 4 + ($urandom % 4),
                    $urandom, int'($urandom % 3), int'($urandom % 3), 1'b0);
            if ($urandom % 4 == 0) idle(1);
        end

        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
